// File: rtl/btn_toggle_pkg.sv
// Shared types and helpers for the push-button toggle conditioner.
package btn_toggle_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } btn_state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/btn_toggle_conditioner_sync_2ff.sv
// 1-bit two-flop synchronizer with synchronous active-high reset to 0.
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/btn_toggle_conditioner.sv
// Turns a raw bouncing push-button into a one-cycle toggle pulse plus a debounced level.
// Optional auto-repeat while held is compiled in with BTN_TOGGLE_AUTOREPEAT_EN.
module btn_toggle_conditioner
   import btn_toggle_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int HOLD_CYCLES     = 64,
   parameter int REPEAT_CYCLES   = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic t,
   output logic btn_level,
   output logic busy
);

   localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)) + 1;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef BTN_TOGGLE_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

   logic             btn_sync;
   btn_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             t_d;
`ifdef BTN_TOGGLE_AUTOREPEAT_EN
   // Set once the first hold pulse has fired; selects the shorter repeat period.
   logic             rep_q, rep_d;
`endif

   sync_2ff u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (btn_raw),
      .q     (btn_sync)
   );

   assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      t_d     = 1'b0;
`ifdef BTN_TOGGLE_AUTOREPEAT_EN
      rep_d   = rep_q;
`endif
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (btn_sync) begin
               state_d = PRESS_WAIT;
               cnt_d   = CNT_ONE;
            end
         end
         PRESS_WAIT: begin
            if (!btn_sync) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d = HELD;
               t_d     = 1'b1;
               cnt_d   = '0;
`ifdef BTN_TOGGLE_AUTOREPEAT_EN
               rep_d   = 1'b0;
`endif
            end else begin
               cnt_d = cnt_inc;
            end
         end
         HELD: begin
            if (!btn_sync) begin
               state_d = RELEASE_WAIT;
               cnt_d   = CNT_ONE;
            end else begin
`ifdef BTN_TOGGLE_AUTOREPEAT_EN
               if ((!rep_q && cnt_q == HOLD_LAST) || (rep_q && cnt_q == REP_LAST)) begin
                  t_d   = 1'b1;
                  cnt_d = '0;
                  rep_d = 1'b1;
               end else begin
                  cnt_d = cnt_inc;
               end
`else
               cnt_d = '0;
`endif
            end
         end
         RELEASE_WAIT: begin
            // The entry cycle already counted as one low sample.
            if (btn_sync) begin
               state_d = HELD;
               cnt_d   = '0;
`ifdef BTN_TOGGLE_AUTOREPEAT_EN
               rep_d   = 1'b0;
`endif
            end else if (cnt_q == DEB_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are registered from the next state so they change with the state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         t         <= 1'b0;
         btn_level <= 1'b0;
         busy      <= 1'b0;
`ifdef BTN_TOGGLE_AUTOREPEAT_EN
         rep_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         t         <= t_d;
         btn_level <= (state_d == HELD) || (state_d == RELEASE_WAIT);
         busy      <= (state_d == PRESS_WAIT) || (state_d == RELEASE_WAIT);
`ifdef BTN_TOGGLE_AUTOREPEAT_EN
         rep_q     <= rep_d;
`endif
      end
   end

endmodule

// File: tb/tb_btn_toggle_conditioner.sv
// Directed bench for btn_toggle_conditioner with DEBOUNCE=4, HOLD=8, REPEAT=3.
// Auto-repeat expectations follow BTN_TOGGLE_AUTOREPEAT_EN.
module tb_btn_toggle_conditioner;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic btn_raw = 1'b0;
   logic t, btn_level, busy;

   int n_checks = 0;
   int n_pass   = 0;

   btn_toggle_conditioner #(
      .DEBOUNCE_CYCLES (4),
      .HOLD_CYCLES     (8),
      .REPEAT_CYCLES   (3)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .btn_raw   (btn_raw),
      .t         (t),
      .btn_level (btn_level),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle; inputs change and outputs are read here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset   = 1'b1;
      btn_raw = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      btn_raw = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         n_checks++;
         if ({t, btn_level, busy} !== 3'b000)
            $display("FAIL reset_outputs cycle %0d got t/level/busy=%b%b%b exp 000", i, t, btn_level, busy);
         else n_pass++;
      end
   endtask

   task automatic test_clean_press();
      logic exp_t, exp_lvl, exp_busy;
      apply_reset();
      btn_raw = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         exp_t    = (i == 6);
         exp_lvl  = (i >= 6);
         exp_busy = (i >= 3) && (i <= 5);
         n_checks++;
         if (t !== exp_t) $display("FAIL press_t cycle %0d got %b exp %b", i, t, exp_t);
         else n_pass++;
         n_checks++;
         if (btn_level !== exp_lvl) $display("FAIL press_level cycle %0d got %b exp %b", i, btn_level, exp_lvl);
         else n_pass++;
         n_checks++;
         if (busy !== exp_busy) $display("FAIL press_busy cycle %0d got %b exp %b", i, busy, exp_busy);
         else n_pass++;
      end
   endtask

   task automatic test_short_bounce();
      logic exp_busy;
      apply_reset();
      for (int i = 1; i <= 12; i++) begin
         btn_raw = (i <= 2);
         tick();
         exp_busy = (i == 3) || (i == 4);
         n_checks++;
         if ({t, btn_level} !== 2'b00) $display("FAIL bounce_t_level cycle %0d got %b%b exp 00", i, t, btn_level);
         else n_pass++;
         n_checks++;
         if (busy !== exp_busy) $display("FAIL bounce_busy cycle %0d got %b exp %b", i, busy, exp_busy);
         else n_pass++;
      end
   endtask

   task automatic test_release_bounce();
      logic exp_lvl, exp_busy;
      apply_reset();
      btn_raw = 1'b1;
      repeat (8) tick();
      n_checks++;
      if (btn_level !== 1'b1) $display("FAIL release_pre_level got %b exp 1", btn_level);
      else n_pass++;
      // Release pattern: low 2, high 1, then low for good.
      for (int j = 1; j <= 12; j++) begin
         btn_raw = (j == 3);
         tick();
         exp_lvl  = (j < 9);
         exp_busy = (j == 3) || (j == 4) || ((j >= 6) && (j <= 8));
         n_checks++;
         if (t !== 1'b0) $display("FAIL release_t cycle %0d got %b exp 0", j, t);
         else n_pass++;
         n_checks++;
         if (btn_level !== exp_lvl) $display("FAIL release_level cycle %0d got %b exp %b", j, btn_level, exp_lvl);
         else n_pass++;
         n_checks++;
         if (busy !== exp_busy) $display("FAIL release_busy cycle %0d got %b exp %b", j, busy, exp_busy);
         else n_pass++;
      end
   endtask

   task automatic test_autorepeat();
      logic exp_t;
      apply_reset();
      btn_raw = 1'b1;
      for (int i = 1; i <= 36; i++) begin
         tick();
`ifdef BTN_TOGGLE_AUTOREPEAT_EN
         exp_t = (i == 6) || ((i >= 14) && (((i - 14) % 3) == 0));
`else
         exp_t = (i == 6);
`endif
         n_checks++;
         if (t !== exp_t) $display("FAIL repeat_t cycle %0d got %b exp %b", i, t, exp_t);
         else n_pass++;
      end
      n_checks++;
      if ({btn_level, busy} !== 2'b10) $display("FAIL repeat_level_busy got %b%b exp 10", btn_level, busy);
      else n_pass++;
   endtask

   task automatic test_reset_mid_press();
      logic exp_t;
      apply_reset();
      btn_raw = 1'b1;
      repeat (4) tick();
      n_checks++;
      if (busy !== 1'b1) $display("FAIL midreset_pre_busy got %b exp 1", busy);
      else n_pass++;
      reset = 1'b1;
      for (int i = 1; i <= 2; i++) begin
         tick();
         n_checks++;
         if ({t, btn_level, busy} !== 3'b000)
            $display("FAIL midreset_during cycle %0d got t/level/busy=%b%b%b exp 000", i, t, btn_level, busy);
         else n_pass++;
      end
      reset = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         exp_t = (i == 6);
         n_checks++;
         if (t !== exp_t) $display("FAIL midreset_t cycle %0d got %b exp %b", i, t, exp_t);
         else n_pass++;
         n_checks++;
         if (btn_level !== (i >= 6)) $display("FAIL midreset_level cycle %0d got %b exp %b", i, btn_level, (i >= 6));
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_short_bounce();
      test_release_bounce();
      test_autorepeat();
      test_reset_mid_press();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
